// File: rtl/fifo_wr_arbiter_if.sv
// Requester and FIFO write-side signals of the round-robin FIFO write arbiter.
// The arbiter uses the slave modport; the environment (requesters plus FIFO) uses master.
interface fifo_wr_arbiter_if #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 8
);
  logic [NUM_REQ-1:0]            i_req_valid;
  logic [NUM_REQ*DATA_WIDTH-1:0] i_req_data;
  logic [NUM_REQ-1:0]            i_req_last;
  logic [NUM_REQ-1:0]            o_req_ready;
  logic                          o_winc;
  logic [DATA_WIDTH-1:0]         o_wdata;
  logic                          i_wfull;
  logic [$clog2(NUM_REQ)-1:0]    o_grant_id;
  logic                          o_busy;

  modport master (
    output i_req_valid, i_req_data, i_req_last, i_wfull,
    input  o_req_ready, o_winc, o_wdata, o_grant_id, o_busy
  );

  modport slave (
    input  i_req_valid, i_req_data, i_req_last, i_wfull,
    output o_req_ready, o_winc, o_wdata, o_grant_id, o_busy
  );
endinterface

// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing one FIFO write port among NUM_REQ bursting requesters.
// state | meaning
// IDLE  | no owner; pick next valid requester after last_grant (one cycle, no beats)
// GRANT | owner holds the port until last beat or MAX_BURST beats are accepted
module fifo_wr_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 8,
  parameter int MAX_BURST  = 4
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  fifo_wr_arbiter_if.slave  bus
);

  localparam int IDW = $clog2(NUM_REQ);
  localparam int CW  = $clog2(MAX_BURST + 1);

  typedef enum logic {IDLE, GRANT} state_t;

  state_t           state, state_nxt;
  logic [IDW-1:0]   owner, owner_nxt;
  logic [IDW-1:0]   last_grant, last_grant_nxt;
  logic [CW-1:0]    beat_cnt, beat_cnt_nxt;

  logic [IDW-1:0]        sel;
  logic                  any_valid;
  logic                  owner_valid;
  logic                  owner_last;
  logic [DATA_WIDTH-1:0] owner_data;
  logic                  accept;
  logic                  burst_end;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state      <= IDLE;
      owner      <= '0;
      last_grant <= IDW'(NUM_REQ - 1);
      beat_cnt   <= '0;
    end else begin
      state      <= state_nxt;
      owner      <= owner_nxt;
      last_grant <= last_grant_nxt;
      beat_cnt   <= beat_cnt_nxt;
    end
  end

  // Scan starts one past the previous owner so the last winner has lowest priority.
  always_comb begin
    logic [IDW-1:0] cand;
    logic           found;
    sel       = '0;
    cand      = '0;
    found     = 1'b0;
    any_valid = |bus.i_req_valid;
    for (int i = 1; i <= NUM_REQ; i++) begin
      cand = IDW'((int'(last_grant) + i) % NUM_REQ);
      if (!found && bus.i_req_valid[cand]) begin
        sel   = cand;
        found = 1'b1;
      end
    end
  end

  always_comb begin
    owner_data = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (owner == IDW'(k)) begin
        owner_data = bus.i_req_data[k*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  assign owner_valid = bus.i_req_valid[owner];
  assign owner_last  = bus.i_req_last[owner];
  assign accept      = (state == GRANT) && owner_valid && !bus.i_wfull;
  assign burst_end   = owner_last || (beat_cnt == CW'(MAX_BURST - 1));

  always_comb begin
    bus.o_req_ready = '0;
    bus.o_busy      = 1'b0;
    bus.o_winc      = accept;
    bus.o_wdata     = owner_data;
    bus.o_grant_id  = owner;
    if (state == GRANT) begin
      bus.o_busy             = 1'b1;
      bus.o_req_ready[owner] = !bus.i_wfull;
    end
  end

  always_comb begin
    state_nxt      = state;
    owner_nxt      = owner;
    last_grant_nxt = last_grant;
    beat_cnt_nxt   = beat_cnt;
    case (state)
      IDLE: begin
        if (any_valid) begin
          owner_nxt    = sel;
          beat_cnt_nxt = '0;
          state_nxt    = GRANT;
        end
      end
      GRANT: begin
        // Owner stays locked through stalls and valid gaps; only accepted beats count.
        if (accept) begin
          beat_cnt_nxt = beat_cnt + CW'(1);
          if (burst_end) begin
            last_grant_nxt = owner;
            state_nxt      = IDLE;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed bench for fifo_wr_arbiter: bursts, round-robin order, burst cap, stalls, async reset.
module tb_fifo_wr_arbiter;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int checks = 0;
  int failures = 0;
  logic [7:0] fifo_q[$];

  always #5 clk = ~clk;

  fifo_wr_arbiter_if #(.NUM_REQ(4), .DATA_WIDTH(8)) bus ();

  fifo_wr_arbiter #(.NUM_REQ(4), .DATA_WIDTH(8), .MAX_BURST(4)) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .bus     (bus)
  );

  // FIFO model plus invariants, sampled mid-cycle
  always @(negedge clk) begin
    if (rst_n) begin
      checks++;
      if (bus.o_winc && bus.i_wfull) begin
        failures++; $display("FAIL inv_winc_while_full winc=%0b wfull=%0b", bus.o_winc, bus.i_wfull);
      end
      checks++;
      if ($countones(bus.o_req_ready) > 1) begin
        failures++; $display("FAIL inv_ready_onehot got=%b", bus.o_req_ready);
      end
      if (bus.o_winc) fifo_q.push_back(bus.o_wdata);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  task automatic cyc();
    @(posedge clk); #1;
  endtask

  task automatic set_data(input int k, input logic [7:0] v);
    bus.i_req_data[k*8 +: 8] = v;
  endtask

  task automatic clear_inputs();
    bus.i_req_valid = '0;
    bus.i_req_last  = '0;
    bus.i_req_data  = '0;
    bus.i_wfull     = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    clear_inputs();
    cyc(); cyc();
    rst_n = 1'b1;
    cyc();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    clear_inputs();
    cyc(); cyc();
    checks++; if (bus.o_busy !== 1'b0) begin failures++; $display("FAIL rst_busy got=%b exp=0", bus.o_busy); end
    checks++; if (bus.o_winc !== 1'b0) begin failures++; $display("FAIL rst_winc got=%b exp=0", bus.o_winc); end
    checks++; if (bus.o_req_ready !== 4'b0000) begin failures++; $display("FAIL rst_ready got=%b exp=0000", bus.o_req_ready); end
    checks++; if (bus.o_grant_id !== 2'd0) begin failures++; $display("FAIL rst_grant_id got=%0d exp=0", bus.o_grant_id); end
    rst_n = 1'b1;
    cyc();
    checks++; if (bus.o_busy !== 1'b0) begin failures++; $display("FAIL idle_no_req_busy got=%b exp=0", bus.o_busy); end
  endtask

  task automatic test_single_burst();
    logic [7:0] exp_d [3] = '{8'h11, 8'h12, 8'h13};
    fifo_q.delete();
    bus.i_req_valid = 4'b0001;
    set_data(0, 8'h11);
    #1;
    checks++; if (bus.o_busy !== 1'b0 || bus.o_req_ready !== 4'b0000 || bus.o_winc !== 1'b0) begin
      failures++; $display("FAIL sb_arb_cycle busy=%b ready=%b winc=%b exp idle", bus.o_busy, bus.o_req_ready, bus.o_winc);
    end
    cyc();
    for (int b = 0; b < 3; b++) begin
      set_data(0, exp_d[b]);
      bus.i_req_last = (b == 2) ? 4'b0001 : 4'b0000;
      #1;
      checks++; if (bus.o_busy !== 1'b1 || bus.o_grant_id !== 2'd0) begin
        failures++; $display("FAIL sb_grant beat=%0d busy=%b id=%0d exp busy=1 id=0", b, bus.o_busy, bus.o_grant_id);
      end
      checks++; if (bus.o_winc !== 1'b1 || bus.o_wdata !== exp_d[b]) begin
        failures++; $display("FAIL sb_beat beat=%0d winc=%b wdata=%h exp winc=1 wdata=%h", b, bus.o_winc, bus.o_wdata, exp_d[b]);
      end
      cyc();
    end
    clear_inputs();
    #1;
    checks++; if (bus.o_busy !== 1'b0 || bus.o_winc !== 1'b0) begin
      failures++; $display("FAIL sb_release busy=%b winc=%b exp 0 0", bus.o_busy, bus.o_winc);
    end
    checks++; if (fifo_q.size() != 3) begin failures++; $display("FAIL sb_fifo_len got=%0d exp=3", fifo_q.size()); end
    for (int i = 0; i < 3; i++) begin
      checks++; if (fifo_q[i] !== exp_d[i]) begin failures++; $display("FAIL sb_fifo_data idx=%0d got=%h exp=%h", i, fifo_q[i], exp_d[i]); end
    end
  endtask

  task automatic test_round_robin();
    int exp_id [5] = '{0, 1, 2, 3, 0};
    logic [3:0] exp_rdy;
    do_reset();
    fifo_q.delete();
    bus.i_req_valid = 4'b1111;
    bus.i_req_last  = 4'b1111;
    for (int k = 0; k < 4; k++) set_data(k, 8'hA0 + 8'(k));
    #1;
    for (int n = 0; n < 5; n++) begin
      cyc();
      exp_rdy = 4'b0001 << exp_id[n];
      checks++; if (bus.o_busy !== 1'b1 || bus.o_grant_id !== 2'(exp_id[n])) begin
        failures++; $display("FAIL rr_order n=%0d busy=%b id=%0d exp id=%0d", n, bus.o_busy, bus.o_grant_id, exp_id[n]);
      end
      checks++; if (bus.o_req_ready !== exp_rdy || bus.o_wdata !== 8'hA0 + 8'(exp_id[n])) begin
        failures++; $display("FAIL rr_ready n=%0d ready=%b wdata=%h exp ready=%b", n, bus.o_req_ready, bus.o_wdata, exp_rdy);
      end
      cyc();
      checks++; if (bus.o_busy !== 1'b0) begin failures++; $display("FAIL rr_idle_gap n=%0d busy=%b exp=0", n, bus.o_busy); end
    end
    clear_inputs();
    checks++; if (fifo_q.size() != 5) begin failures++; $display("FAIL rr_fifo_len got=%0d exp=5", fifo_q.size()); end
  endtask

  task automatic test_max_burst();
    logic [7:0] exp_d [5] = '{8'h20, 8'h21, 8'h22, 8'h23, 8'h30};
    fifo_q.delete();
    bus.i_req_valid = 4'b1100;
    bus.i_req_last  = 4'b0000;
    set_data(2, 8'h20);
    set_data(3, 8'h30);
    cyc();
    for (int b = 0; b < 4; b++) begin
      set_data(2, 8'h20 + 8'(b));
      #1;
      checks++; if (bus.o_grant_id !== 2'd2 || bus.o_winc !== 1'b1 || bus.o_wdata !== 8'h20 + 8'(b)) begin
        failures++; $display("FAIL mb_beat b=%0d id=%0d winc=%b wdata=%h exp id=2 winc=1", b, bus.o_grant_id, bus.o_winc, bus.o_wdata);
      end
      cyc();
    end
    checks++; if (bus.o_busy !== 1'b0) begin failures++; $display("FAIL mb_forced_release busy=%b exp=0", bus.o_busy); end
    cyc();
    checks++; if (bus.o_busy !== 1'b1 || bus.o_grant_id !== 2'd3) begin
      failures++; $display("FAIL mb_next_grant busy=%b id=%0d exp id=3", bus.o_busy, bus.o_grant_id);
    end
    bus.i_req_last = 4'b1000;
    cyc();
    clear_inputs();
    #1;
    checks++; if (fifo_q.size() != 5) begin failures++; $display("FAIL mb_fifo_len got=%0d exp=5", fifo_q.size()); end
    for (int i = 0; i < 5; i++) begin
      checks++; if (fifo_q[i] !== exp_d[i]) begin failures++; $display("FAIL mb_fifo_data idx=%0d got=%h exp=%h", i, fifo_q[i], exp_d[i]); end
    end
  endtask

  task automatic test_full_stall();
    logic [7:0] exp_d [4] = '{8'h41, 8'h42, 8'h43, 8'h44};
    fifo_q.delete();
    bus.i_req_valid = 4'b0010;
    set_data(1, 8'h41);
    cyc();
    checks++; if (bus.o_grant_id !== 2'd1 || bus.o_winc !== 1'b1 || bus.o_wdata !== 8'h41) begin
      failures++; $display("FAIL fs_first id=%0d winc=%b wdata=%h exp id=1 winc=1 wdata=41", bus.o_grant_id, bus.o_winc, bus.o_wdata);
    end
    cyc();
    set_data(1, 8'h42);
    bus.i_wfull    = 1'b1;
    bus.i_req_last = 4'b0010;
    for (int s = 0; s < 3; s++) begin
      #1;
      checks++; if (bus.o_winc !== 1'b0 || bus.o_req_ready !== 4'b0000 || bus.o_busy !== 1'b1 || bus.o_grant_id !== 2'd1) begin
        failures++; $display("FAIL fs_stall s=%0d winc=%b ready=%b busy=%b id=%0d", s, bus.o_winc, bus.o_req_ready, bus.o_busy, bus.o_grant_id);
      end
      cyc();
    end
    bus.i_wfull    = 1'b0;
    bus.i_req_last = 4'b0000;
    for (int b = 1; b < 4; b++) begin
      set_data(1, exp_d[b]);
      #1;
      checks++; if (bus.o_busy !== 1'b1 || bus.o_winc !== 1'b1 || bus.o_wdata !== exp_d[b]) begin
        failures++; $display("FAIL fs_resume b=%0d busy=%b winc=%b wdata=%h exp %h", b, bus.o_busy, bus.o_winc, bus.o_wdata, exp_d[b]);
      end
      cyc();
    end
    clear_inputs();
    #1;
    checks++; if (bus.o_busy !== 1'b0) begin failures++; $display("FAIL fs_release busy=%b exp=0", bus.o_busy); end
    checks++; if (fifo_q.size() != 4) begin failures++; $display("FAIL fs_fifo_len got=%0d exp=4", fifo_q.size()); end
    for (int i = 0; i < 4; i++) begin
      checks++; if (fifo_q[i] !== exp_d[i]) begin failures++; $display("FAIL fs_fifo_data idx=%0d got=%h exp=%h", i, fifo_q[i], exp_d[i]); end
    end
  endtask

  task automatic test_valid_gap();
    logic [7:0] exp_d [3] = '{8'h51, 8'h52, 8'h61};
    do_reset();
    fifo_q.delete();
    bus.i_req_valid = 4'b0011;
    set_data(0, 8'h51);
    set_data(1, 8'h61);
    cyc();
    checks++; if (bus.o_grant_id !== 2'd0 || bus.o_wdata !== 8'h51 || bus.o_winc !== 1'b1) begin
      failures++; $display("FAIL vg_first id=%0d wdata=%h winc=%b exp id=0 wdata=51", bus.o_grant_id, bus.o_wdata, bus.o_winc);
    end
    cyc();
    bus.i_req_valid = 4'b0010;
    for (int s = 0; s < 2; s++) begin
      #1;
      checks++; if (bus.o_grant_id !== 2'd0 || bus.o_busy !== 1'b1 || bus.o_winc !== 1'b0 || bus.o_req_ready !== 4'b0001) begin
        failures++; $display("FAIL vg_locked s=%0d id=%0d busy=%b winc=%b ready=%b exp id=0 ready=0001", s, bus.o_grant_id, bus.o_busy, bus.o_winc, bus.o_req_ready);
      end
      cyc();
    end
    bus.i_req_valid = 4'b0011;
    bus.i_req_last  = 4'b0001;
    set_data(0, 8'h52);
    #1;
    checks++; if (bus.o_winc !== 1'b1 || bus.o_wdata !== 8'h52 || bus.o_grant_id !== 2'd0) begin
      failures++; $display("FAIL vg_resume winc=%b wdata=%h id=%0d exp wdata=52 id=0", bus.o_winc, bus.o_wdata, bus.o_grant_id);
    end
    cyc();
    bus.i_req_valid = 4'b0010;
    bus.i_req_last  = 4'b0010;
    #1;
    checks++; if (bus.o_busy !== 1'b0) begin failures++; $display("FAIL vg_release busy=%b exp=0", bus.o_busy); end
    cyc();
    checks++; if (bus.o_grant_id !== 2'd1 || bus.o_busy !== 1'b1 || bus.o_wdata !== 8'h61) begin
      failures++; $display("FAIL vg_next id=%0d busy=%b wdata=%h exp id=1 wdata=61", bus.o_grant_id, bus.o_busy, bus.o_wdata);
    end
    cyc();
    clear_inputs();
    #1;
    checks++; if (fifo_q.size() != 3) begin failures++; $display("FAIL vg_fifo_len got=%0d exp=3", fifo_q.size()); end
    for (int i = 0; i < 3; i++) begin
      checks++; if (fifo_q[i] !== exp_d[i]) begin failures++; $display("FAIL vg_fifo_data idx=%0d got=%h exp=%h", i, fifo_q[i], exp_d[i]); end
    end
  endtask

  task automatic test_async_reset();
    // last_grant is 1 here, so an unreset last_grant would pick requester 3 over 0
    bus.i_req_valid = 4'b1000;
    set_data(3, 8'h77);
    cyc();
    checks++; if (bus.o_grant_id !== 2'd3 || bus.o_winc !== 1'b1) begin
      failures++; $display("FAIL ar_pre id=%0d winc=%b exp id=3 winc=1", bus.o_grant_id, bus.o_winc);
    end
    cyc();
    #2;
    rst_n = 1'b0;
    #1;
    checks++; if (bus.o_winc !== 1'b0 || bus.o_busy !== 1'b0 || bus.o_req_ready !== 4'b0000) begin
      failures++; $display("FAIL ar_drop winc=%b busy=%b ready=%b exp 0 0 0000", bus.o_winc, bus.o_busy, bus.o_req_ready);
    end
    bus.i_req_valid = 4'b1001;
    set_data(0, 8'h88);
    cyc(); cyc();
    rst_n = 1'b1;
    #1;
    checks++; if (bus.o_busy !== 1'b0) begin failures++; $display("FAIL ar_post_idle busy=%b exp=0", bus.o_busy); end
    cyc();
    checks++; if (bus.o_busy !== 1'b1 || bus.o_grant_id !== 2'd0 || bus.o_wdata !== 8'h88) begin
      failures++; $display("FAIL ar_first_grant busy=%b id=%0d wdata=%h exp id=0 wdata=88", bus.o_busy, bus.o_grant_id, bus.o_wdata);
    end
    bus.i_req_last = 4'b0001;
    cyc();
    clear_inputs();
    #1;
    checks++; if (bus.o_busy !== 1'b0) begin failures++; $display("FAIL ar_end busy=%b exp=0", bus.o_busy); end
  endtask

  initial begin
    clear_inputs();
    test_reset();
    test_single_burst();
    test_round_robin();
    test_max_burst();
    test_full_stall();
    test_valid_gap();
    test_async_reset();
    cyc();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/fifo_wr_arbiter.md
Name: fifo_wr_arbiter

Overview:
- Round-robin arbiter that shares one FIFO write port between NUM_REQ requesters.
- Grants the port to one requester per burst and drives o_winc/o_wdata into the FIFO write side.
- Honours the FIFO full flag; sits in the write clock domain, directly in front of the FIFO write interface.

Parameters:
- NUM_REQ, 4, number of requesters (>=2).
- DATA_WIDTH, 8, data width; must match the FIFO.
- MAX_BURST, 4, maximum beats per grant (>=1).

Ports:
- i_clk  input  1  write-domain clock.
- i_rst_n  input  1  asynchronous active-low reset.
- i_req_valid  input  NUM_REQ  per-requester beat valid.
- i_req_data  input  NUM_REQ*DATA_WIDTH  packed beat data; requester k occupies bits [k*DATA_WIDTH +: DATA_WIDTH].
- i_req_last  input  NUM_REQ  marks the final beat of a burst.
- o_req_ready  output  NUM_REQ  per-requester beat accept.
- o_winc  output  1  FIFO write enable.
- o_wdata  output  DATA_WIDTH  FIFO write data.
- i_wfull  input  1  FIFO full flag.
- o_grant_id  output  $clog2(NUM_REQ)  current owner; meaningful only while o_busy=1.
- o_busy  output  1  a grant is active.

Interface decision: one clock (i_clk); reset i_rst_n is asynchronous and active-low.

Behaviour:
- States: IDLE, GRANT.
- Registered state: state, owner (o_grant_id), last_grant, beat_cnt (width $clog2(MAX_BURST+1)).

Reset (async, any time, including mid-burst):
- state=IDLE, o_grant_id=0, last_grant=NUM_REQ-1, beat_cnt=0.
- Outputs: o_busy=0, o_winc=0, o_req_ready=0.
- Any partially sent burst is abandoned; there is no replay.

IDLE:
- o_req_ready all 0, o_winc=0.
- If any i_req_valid is set, select the first set bit scanning from last_grant+1 upward, modulo NUM_REQ.
- Next edge: owner<=selected, beat_cnt<=0, state<=GRANT.
- Arbitration costs 1 cycle; no beat transfers in IDLE.

GRANT, owner g (combinational outputs):
- o_req_ready[g] = !i_wfull; all other ready bits 0.
- o_winc = i_req_valid[g] && !i_wfull.
- o_wdata = data slice g, passed combinationally with zero latency.
- o_busy=1.

Beat accounting:
- A beat is accepted on an edge where o_winc=1.
- Each accepted beat increments beat_cnt.

Burst termination:
- A burst ends on an accepted beat with i_req_last[g]=1, OR on the accepted beat that brings beat_cnt to MAX_BURST.
- On that edge: last_grant<=g, state<=IDLE.

Stalls:
- i_wfull=1: no accept and no count; the grant is held indefinitely.
- Owner deasserts valid mid-burst: the grant is held (locked) and other requesters wait.
- i_req_last on an unaccepted cycle has no effect.

Fairness:
- Every valid requester is granted within NUM_REQ grants.
- A single requester that is continuously valid is re-granted after one IDLE cycle.

Simultaneous events:
- Termination and a new request in the same cycle: the new request is arbitrated in the following IDLE cycle, with last_grant already updated.

Invariants:
- o_winc never asserts while i_wfull=1.
- At most one o_req_ready bit is high.

Test Plan:
- Reset, then request 0 valid with a 3-beat burst 0x11,0x12,0x13 (last on 0x13), FIFO not full → grant after 1 IDLE cycle; 3 consecutive o_winc cycles with o_wdata 0x11,0x12,0x13; o_grant_id=0; returns to IDLE; o_busy low.
- Requesters 0–3 all continuously valid, each burst 1 beat (last=1) → grant order 0,1,2,3,0; each grant separated by one IDLE cycle.
- Requester 2 valid with last never set, MAX_BURST=4 → exactly 4 beats accepted, then forced release; if requester 3 is valid it receives the next grant.
- During a burst, i_wfull=1 for 3 cycles → o_winc=0 and o_req_ready[g]=0 for those cycles, beat_cnt frozen; the burst resumes when i_wfull=0 with no data loss or duplication (FIFO model contents match the sent sequence).
- Owner deasserts valid for 2 cycles mid-burst while requester 1 is valid → o_grant_id is unchanged and requester 1 gets no ready; the burst completes before requester 1 is granted.
- Assert i_rst_n=0 asynchronously mid-burst (between clock edges) → o_winc, o_busy and o_req_ready drop immediately; after release with requesters 0 and 3 valid, requester 0 is granted first.
